pma_region_programmer: RTL and testbench

- Run-time writer for the PMA region tables: non-idempotent, execute, cached and shared.
- Accepts region programming requests over a valid/ready request channel and validates each rule, including a serialized overlap scan.
- Stages rules in a shadow table. On COMMIT, compacts and atomically publishes them as packed base/length arrays plus per-kind rule counts, in exactly the form the core's region-membership checks consume (the first count entries are valid).
- Sits between the platform CSR/config bus and the core's PMA inputs.

---
 rtl/pma_region_programmer.sv | 236 +++++++++++++++++++++++
 tb/tb_pma_region_programmer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_region_programmer.sv
// Purpose: run-time writer for the PMA region tables (non-idempotent, exec, cached, shared).
// Latency: errors and CLEAR respond 1 cycle after accept; WRITE and COMMIT respond NrMaxRules+1 cycles after accept.
// Backpressure: one request in flight; req_ready_o is high only in IDLE, and the response is held until rsp_ready_i.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_*                   request channel (op/kind/idx/base/len), valid/ready
//   rsp_*                   response channel, code held stable until accepted
//   dirty_o                 shadow table differs from the published table
//   region_base_o/len_o     published tables, packed [kind][entry], first cnt entries valid
//   region_cnt_o            published rule count per kind
module pma_region_programmer #(
   parameter int unsigned NrMaxRules = 16,
   parameter int unsigned AddrWidth  = 64
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic                                       req_valid_i,
   output logic                                       req_ready_o,
   input  logic [1:0]                                 req_op_i,
   input  logic [1:0]                                 req_kind_i,
   input  logic [$clog2(NrMaxRules):0]                req_idx_i,
   input  logic [AddrWidth-1:0]                       req_base_i,
   input  logic [AddrWidth-1:0]                       req_len_i,
   output logic                                       rsp_valid_o,
   input  logic                                       rsp_ready_i,
   output logic [2:0]                                 rsp_code_o,
   output logic                                       dirty_o,
   output logic [4*NrMaxRules*AddrWidth-1:0]          region_base_o,
   output logic [4*NrMaxRules*AddrWidth-1:0]          region_len_o,
   output logic [4*$clog2(NrMaxRules+1)-1:0]          region_cnt_o
);

   localparam int unsigned KW = $clog2(NrMaxRules);
   localparam int unsigned CW = $clog2(NrMaxRules+1);
   localparam int unsigned IW = KW + 1;

   localparam logic [1:0] OP_WRITE  = 2'd0;
   localparam logic [1:0] OP_CLEAR  = 2'd1;
   localparam logic [1:0] OP_COMMIT = 2'd2;
   localparam logic [1:0] OP_RSVD   = 2'd3;

   localparam logic [2:0] RC_OK       = 3'd0;
   localparam logic [2:0] RC_BAD_IDX  = 3'd1;
   localparam logic [2:0] RC_ZERO_LEN = 3'd2;
   localparam logic [2:0] RC_WRAP     = 3'd3;
   localparam logic [2:0] RC_OVERLAP  = 3'd4;
   localparam logic [2:0] RC_BAD_OP   = 3'd5;

   typedef enum logic [1:0] {IDLE, SCAN, COMPACT, RESP} state_e;

   state_e state_q, state_d;

   // captured request
   logic [1:0]           kind_q;
   logic [KW-1:0]        idx_q;
   logic [AddrWidth-1:0] base_q;
   logic [AddrWidth-1:0] len_q;
   logic [KW-1:0]        scan_cnt_q;
   logic                 ovl_q;

   // shadow table
   logic                 sh_vld  [4][NrMaxRules];
   logic [AddrWidth-1:0] sh_base [4][NrMaxRules];
   logic [AddrWidth-1:0] sh_len  [4][NrMaxRules];

   // staging table built during COMPACT, plus its next-cycle view
   logic [AddrWidth-1:0] stg_base   [4][NrMaxRules];
   logic [AddrWidth-1:0] stg_len    [4][NrMaxRules];
   logic [CW-1:0]        stg_cnt    [4];
   logic [AddrWidth-1:0] stg_base_n [4][NrMaxRules];
   logic [AddrWidth-1:0] stg_len_n  [4][NrMaxRules];
   logic [CW-1:0]        stg_cnt_n  [4];

   logic [2:0]           chk_code;
   logic [AddrWidth:0]   req_end;
   logic [AddrWidth:0]   q_end;
   logic [AddrWidth:0]   k_end;
   logic                 scan_hit;
   logic                 scan_last;

   assign req_ready_o = (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);

   // 65-bit end address so a region ending exactly at 2^AddrWidth is representable
   assign req_end = {1'b0, req_base_i} + {1'b0, req_len_i};

   always_comb begin
      chk_code = RC_OK;
      if (req_op_i == OP_RSVD) begin
         chk_code = RC_BAD_OP;
      end else if (req_op_i != OP_COMMIT && req_idx_i >= IW'(NrMaxRules)) begin
         chk_code = RC_BAD_IDX;
      end else if (req_op_i == OP_WRITE && req_len_i == '0) begin
         chk_code = RC_ZERO_LEN;
      end else if (req_op_i == OP_WRITE && req_end > {1'b1, {AddrWidth{1'b0}}}) begin
         chk_code = RC_WRAP;
      end
   end

   // One shadow entry per SCAN cycle; half-open intervals intersect iff each starts before the other ends.
   assign q_end     = {1'b0, base_q} + {1'b0, len_q};
   assign k_end     = {1'b0, sh_base[kind_q][scan_cnt_q]} + {1'b0, sh_len[kind_q][scan_cnt_q]};
   assign scan_hit  = (scan_cnt_q != idx_q) && sh_vld[kind_q][scan_cnt_q] &&
                      ({1'b0, base_q} < k_end) && ({1'b0, sh_base[kind_q][scan_cnt_q]} < q_end);
   assign scan_last = (scan_cnt_q == KW'(NrMaxRules-1));

   // Compaction step: append shadow slot scan_cnt_q of every kind when valid.
   // The last step's result is published directly, so the swap lands on the response cycle.
   always_comb begin
      stg_base_n = stg_base;
      stg_len_n  = stg_len;
      stg_cnt_n  = stg_cnt;
      for (int kk = 0; kk < 4; kk++) begin
         if (sh_vld[kk][scan_cnt_q]) begin
            stg_base_n[kk][stg_cnt[kk][KW-1:0]] = sh_base[kk][scan_cnt_q];
            stg_len_n[kk][stg_cnt[kk][KW-1:0]]  = sh_len[kk][scan_cnt_q];
            stg_cnt_n[kk]                       = stg_cnt[kk] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               if (chk_code != RC_OK)          state_d = RESP;
               else if (req_op_i == OP_WRITE)  state_d = SCAN;
               else if (req_op_i == OP_COMMIT) state_d = COMPACT;
               else                            state_d = RESP;
            end
         end
         SCAN:    if (scan_last) state_d = RESP;
         COMPACT: if (scan_last) state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         kind_q        <= '0;
         idx_q         <= '0;
         base_q        <= '0;
         len_q         <= '0;
         scan_cnt_q    <= '0;
         ovl_q         <= 1'b0;
         rsp_code_o    <= RC_OK;
         dirty_o       <= 1'b0;
         region_base_o <= '0;
         region_len_o  <= '0;
         region_cnt_o  <= '0;
         for (int kk = 0; kk < 4; kk++) begin
            stg_cnt[kk] <= '0;
            for (int e = 0; e < NrMaxRules; e++) begin
               sh_vld[kk][e]   <= 1'b0;
               sh_base[kk][e]  <= '0;
               sh_len[kk][e]   <= '0;
               stg_base[kk][e] <= '0;
               stg_len[kk][e]  <= '0;
            end
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  kind_q     <= req_kind_i;
                  idx_q      <= req_idx_i[KW-1:0];
                  base_q     <= req_base_i;
                  len_q      <= req_len_i;
                  scan_cnt_q <= '0;
                  ovl_q      <= 1'b0;
                  rsp_code_o <= chk_code;
                  if (chk_code == RC_OK && req_op_i == OP_CLEAR) begin
                     sh_vld[req_kind_i][req_idx_i[KW-1:0]] <= 1'b0;
                     dirty_o                               <= 1'b1;
                  end
                  if (chk_code == RC_OK && req_op_i == OP_COMMIT) begin
                     for (int kk = 0; kk < 4; kk++) begin
                        stg_cnt[kk] <= '0;
                        for (int e = 0; e < NrMaxRules; e++) begin
                           stg_base[kk][e] <= '0;
                           stg_len[kk][e]  <= '0;
                        end
                     end
                  end
               end
            end
            SCAN: begin
               ovl_q      <= ovl_q | scan_hit;
               scan_cnt_q <= scan_cnt_q + KW'(1);
               if (scan_last) begin
                  if (ovl_q | scan_hit) begin
                     rsp_code_o <= RC_OVERLAP;
                  end else begin
                     sh_vld[kind_q][idx_q]  <= 1'b1;
                     sh_base[kind_q][idx_q] <= base_q;
                     sh_len[kind_q][idx_q]  <= len_q;
                     dirty_o                <= 1'b1;
                     rsp_code_o             <= RC_OK;
                  end
               end
            end
            COMPACT: begin
               stg_base   <= stg_base_n;
               stg_len    <= stg_len_n;
               stg_cnt    <= stg_cnt_n;
               scan_cnt_q <= scan_cnt_q + KW'(1);
               if (scan_last) begin
                  for (int kk = 0; kk < 4; kk++) begin
                     region_cnt_o[kk*CW +: CW] <= stg_cnt_n[kk];
                     for (int e = 0; e < NrMaxRules; e++) begin
                        region_base_o[(kk*NrMaxRules+e)*AddrWidth +: AddrWidth] <= stg_base_n[kk][e];
                        region_len_o[(kk*NrMaxRules+e)*AddrWidth +: AddrWidth]  <= stg_len_n[kk][e];
                     end
                  end
                  dirty_o    <= 1'b0;
                  rsp_code_o <= RC_OK;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pma_region_programmer.sv
module tb_pma_region_programmer;

   localparam int N  = 16;
   localparam int AW = 64;
   localparam int CW = 5;
   localparam int TW = 4*N*AW;

   typedef struct packed {
      logic [2:0] code;
      logic [7:0] lat;
   } rsp_t;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            req_valid_i = 1'b0;
   logic            req_ready_o;
   logic [1:0]      req_op_i = '0;
   logic [1:0]      req_kind_i = '0;
   logic [4:0]      req_idx_i = '0;
   logic [AW-1:0]   req_base_i = '0;
   logic [AW-1:0]   req_len_i = '0;
   logic            rsp_valid_o;
   logic            rsp_ready_i = 1'b0;
   logic [2:0]      rsp_code_o;
   logic            dirty_o;
   logic [TW-1:0]   region_base_o;
   logic [TW-1:0]   region_len_o;
   logic [4*CW-1:0] region_cnt_o;

   pma_region_programmer #(.NrMaxRules(N), .AddrWidth(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op_i(req_op_i), .req_kind_i(req_kind_i), .req_idx_i(req_idx_i),
      .req_base_i(req_base_i), .req_len_i(req_len_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_code_o(rsp_code_o),
      .dirty_o(dirty_o), .region_base_o(region_base_o), .region_len_o(region_len_o),
      .region_cnt_o(region_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [1:0] WR = 2'd0, CLR = 2'd1, CMT = 2'd2, RSV = 2'd3;
   localparam logic [1:0] NONIDEM = 2'd0, EXEC = 2'd1, CACHED = 2'd2, SHARED = 2'd3;
   localparam logic [2:0] OK = 3'd0, BAD_IDX = 3'd1, ZERO_LEN = 3'd2, WRAP = 3'd3, OVERLAP = 3'd4, BAD_OP = 3'd5;
   localparam logic [7:0] LAT_SHORT = 8'd1, LAT_LONG = 8'(N+1);

   int total_n = 0;
   int pass_n  = 0;
   rsp_t exp_q[$];

   // reference shadow table and the published image expected from it
   bit            m_vld  [4][N];
   logic [AW-1:0] m_base [4][N];
   logic [AW-1:0] m_len  [4][N];
   logic [TW-1:0] pub_b;
   logic [TW-1:0] pub_l;
   logic [4*CW-1:0] pub_c;

   // locals shared by the test tasks (only one runs at a time)
   rsp_t obs, e;
   bit   rdy0, stable;
   int   d;

   function automatic int first_diff(input logic [TW-1:0] a, input logic [TW-1:0] b);
      for (int i = 0; i < 4*N; i++)
         if (a[i*AW +: AW] !== b[i*AW +: AW]) return i;
      return 0;
   endfunction

   task automatic model_clear();
      for (int kk = 0; kk < 4; kk++)
         for (int k = 0; k < N; k++) begin
            m_vld[kk][k] = 0; m_base[kk][k] = '0; m_len[kk][k] = '0;
         end
      pub_b = '0; pub_l = '0; pub_c = '0;
   endtask

   task automatic model_publish();
      int c;
      pub_b = '0; pub_l = '0; pub_c = '0;
      for (int kk = 0; kk < 4; kk++) begin
         c = 0;
         for (int k = 0; k < N; k++)
            if (m_vld[kk][k]) begin
               pub_b[(kk*N+c)*AW +: AW] = m_base[kk][k];
               pub_l[(kk*N+c)*AW +: AW] = m_len[kk][k];
               c++;
            end
         pub_c[kk*CW +: CW] = CW'(c);
      end
   endtask

   // Drives one request, records the expectation, waits (bounded) for the response,
   // optionally stalls rsp_ready_i for 'hold' cycles, then hands the response off.
   task automatic send_req(input logic [1:0] op, input logic [1:0] kind, input logic [4:0] idx,
                           input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic [2:0] exp_code, input logic [7:0] exp_lat, input int hold,
                           output rsp_t o, output bit rdy_at_drive, output bit stab);
      int lat;
      @(negedge clk_i);
      rdy_at_drive = req_ready_o;
      req_valid_i = 1'b1; req_op_i = op; req_kind_i = kind; req_idx_i = idx;
      req_base_i = base; req_len_i = len;
      exp_q.push_back('{code: exp_code, lat: exp_lat});
      if (exp_code == OK) begin
         if (op == WR) begin
            m_vld[kind][idx[3:0]] = 1; m_base[kind][idx[3:0]] = base; m_len[kind][idx[3:0]] = len;
         end else if (op == CLR) begin
            m_vld[kind][idx[3:0]] = 0;
         end else if (op == CMT) begin
            model_publish();
         end
      end
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      lat = 1;
      @(negedge clk_i);
      while (!rsp_valid_o && lat < 100) begin
         @(negedge clk_i);
         lat++;
      end
      stab = 1;
      if (!rsp_valid_o) begin
         o = '{code: 3'd7, lat: 8'(lat)};
      end else begin
         o = '{code: rsp_code_o, lat: 8'(lat)};
         repeat (hold) begin
            @(negedge clk_i);
            if (!rsp_valid_o || rsp_code_o !== o.code || req_ready_o) stab = 0;
         end
         rsp_ready_i = 1'b1;
         @(posedge clk_i);
         #1 rsp_ready_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      total_n++; if ({req_ready_o, rsp_valid_o, rsp_code_o, dirty_o} !== 6'b100000)
         $display("FAIL reset_ctrl got rdy/vld/code/dirty=%b%b/%0d/%b need 1/0/0/0", req_ready_o, rsp_valid_o, rsp_code_o, dirty_o);
      else pass_n++;
      total_n++; if (region_base_o !== '0 || region_len_o !== '0 || region_cnt_o !== '0)
         $display("FAIL reset_tables got cnt=%h nonzero_base=%b nonzero_len=%b need all 0", region_cnt_o, |region_base_o, |region_len_o);
      else pass_n++;
   endtask

   task automatic test_exec_commit();
      send_req(WR, EXEC, 5'd0, 64'h8000_0000, 64'h4000_0000, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL exec_write code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      @(negedge clk_i);
      total_n++; if (dirty_o !== 1'b1 || region_cnt_o !== '0) $display("FAIL exec_pre_commit dirty/cnt got %b/%h need 1/0", dirty_o, region_cnt_o); else pass_n++;
      send_req(CMT, NONIDEM, 5'd0, '0, '0, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL exec_commit code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      @(negedge clk_i);
      total_n++; if (region_cnt_o[EXEC*CW +: CW] !== 5'd1 || region_base_o[(EXEC*N)*AW +: AW] !== 64'h8000_0000 || dirty_o !== 1'b0)
         $display("FAIL exec_published cnt/base/dirty got %0d/%h/%b need 1/80000000/0", region_cnt_o[EXEC*CW +: CW], region_base_o[(EXEC*N)*AW +: AW], dirty_o);
      else pass_n++;
      d = first_diff(region_len_o, pub_l);
      total_n++; if (region_len_o !== pub_l) $display("FAIL exec_len entry %0d got %h need %h", d, region_len_o[d*AW +: AW], pub_l[d*AW +: AW]); else pass_n++;
   endtask

   task automatic test_overlap();
      send_req(WR, CACHED, 5'd3, 64'h1000, 64'h1000, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL ovl_first code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      send_req(WR, CACHED, 5'd5, 64'h1800, 64'h100, OVERLAP, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL ovl_hit code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      send_req(WR, CACHED, 5'd5, 64'h2000, 64'h100, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL ovl_touch code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      send_req(WR, CACHED, 5'd3, 64'h1000, 64'h1000, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL ovl_rewrite_self code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      @(negedge clk_i);
      d = first_diff(region_base_o, pub_b);
      total_n++; if (region_base_o !== pub_b || region_cnt_o !== pub_c)
         $display("FAIL ovl_active_untouched entry %0d got %h cnt %h need %h cnt %h", d, region_base_o[d*AW +: AW], region_cnt_o, pub_b[d*AW +: AW], pub_c);
      else pass_n++;
   endtask

   task automatic test_errors();
      send_req(WR, SHARED, 5'd0, 64'h4000, 64'h0, ZERO_LEN, LAT_SHORT, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL err_zero_len code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      send_req(WR, SHARED, 5'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, WRAP, LAT_SHORT, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL err_wrap code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      send_req(WR, SHARED, 5'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL err_top_edge code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      send_req(WR, SHARED, 5'd16, 64'h4000, 64'h0, BAD_IDX, LAT_SHORT, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL err_bad_idx code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      send_req(CLR, SHARED, 5'd16, '0, '0, BAD_IDX, LAT_SHORT, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL err_clr_bad_idx code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      send_req(RSV, SHARED, 5'd16, '0, '0, BAD_OP, LAT_SHORT, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL err_bad_op code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      // errors must not disturb the shadow: republish and compare against the reference
      send_req(CMT, NONIDEM, 5'd0, '0, '0, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL err_commit code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      @(negedge clk_i);
      d = first_diff(region_base_o, pub_b);
      total_n++; if (region_base_o !== pub_b || region_cnt_o !== pub_c)
         $display("FAIL err_published entry %0d got %h cnt %h need %h cnt %h", d, region_base_o[d*AW +: AW], region_cnt_o, pub_b[d*AW +: AW], pub_c);
      else pass_n++;
   endtask

   task automatic test_compaction();
      logic [4:0] slots [3] = '{5'd2, 5'd7, 5'd15};
      for (int i = 0; i < 3; i++) begin
         send_req(WR, NONIDEM, slots[i], 64'h10000 * (slots[i] + 1), 64'h100, OK, LAT_LONG, 0, obs, rdy0, stable);
         e = exp_q.pop_front();
         total_n++; if (obs !== e) $display("FAIL cmp_write%0d code/lat got %0d/%0d need %0d/%0d", i, obs.code, obs.lat, e.code, e.lat); else pass_n++;
      end
      send_req(CMT, NONIDEM, 5'd0, '0, '0, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL cmp_commit code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      @(negedge clk_i);
      total_n++; if (region_cnt_o[0 +: CW] !== 5'd3 || region_base_o[0 +: AW] !== 64'h30000 ||
                     region_base_o[AW +: AW] !== 64'h80000 || region_base_o[2*AW +: AW] !== 64'h100000 ||
                     region_base_o[3*AW +: 13*AW] !== '0)
         $display("FAIL cmp_order cnt=%0d e0=%h e1=%h e2=%h need 3/30000/80000/100000 rest 0",
                  region_cnt_o[0 +: CW], region_base_o[0 +: AW], region_base_o[AW +: AW], region_base_o[2*AW +: AW]);
      else pass_n++;
      d = first_diff(region_len_o, pub_l);
      total_n++; if (region_len_o !== pub_l) $display("FAIL cmp_len entry %0d got %h need %h", d, region_len_o[d*AW +: AW], pub_l[d*AW +: AW]); else pass_n++;
      send_req(CLR, NONIDEM, 5'd7, '0, '0, OK, LAT_SHORT, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL cmp_clear code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      @(negedge clk_i);
      total_n++; if (dirty_o !== 1'b1 || region_cnt_o[0 +: CW] !== 5'd3) $display("FAIL cmp_clear_state dirty/cnt got %b/%0d need 1/3", dirty_o, region_cnt_o[0 +: CW]); else pass_n++;
      send_req(CMT, NONIDEM, 5'd0, '0, '0, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL cmp_commit2 code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      @(negedge clk_i);
      total_n++; if (region_cnt_o[0 +: CW] !== 5'd2 || region_base_o[AW +: AW] !== 64'h100000 || region_base_o[2*AW +: AW] !== '0)
         $display("FAIL cmp_after_clear cnt=%0d e1=%h e2=%h need 2/100000/0", region_cnt_o[0 +: CW], region_base_o[AW +: AW], region_base_o[2*AW +: AW]);
      else pass_n++;
      d = first_diff(region_base_o, pub_b);
      total_n++; if (region_base_o !== pub_b || region_cnt_o !== pub_c)
         $display("FAIL cmp_model entry %0d got %h cnt %h need %h cnt %h", d, region_base_o[d*AW +: AW], region_cnt_o, pub_b[d*AW +: AW], pub_c);
      else pass_n++;
   endtask

   task automatic test_back_to_back();
      send_req(RSV, EXEC, 5'd0, '0, '0, BAD_OP, LAT_SHORT, 5, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL bp_code code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      total_n++; if (stable !== 1'b1) $display("FAIL bp_hold_stable got %b need 1", stable); else pass_n++;
      send_req(CLR, EXEC, 5'd9, '0, '0, OK, LAT_SHORT, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (rdy0 !== 1'b1) $display("FAIL bp_ready_after_handshake got %b need 1", rdy0); else pass_n++;
      total_n++; if (obs !== e) $display("FAIL bp_next_req code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
   endtask

   task automatic test_reset_mid_compact();
      bit quiet;
      send_req(WR, SHARED, 5'd5, 64'h5000, 64'h10, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL rst_pre_write code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_op_i = CMT;
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      quiet = 1;
      repeat (7) begin
         @(negedge clk_i);
         if (rsp_valid_o) quiet = 0;
         @(posedge clk_i);
      end
      @(negedge clk_i);
      if (rsp_valid_o) quiet = 0;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      model_clear();
      @(negedge clk_i);
      total_n++; if ({req_ready_o, rsp_valid_o, rsp_code_o, dirty_o} !== 6'b100000)
         $display("FAIL rst_mid_ctrl got rdy/vld/code/dirty=%b%b/%0d/%b need 1/0/0/0", req_ready_o, rsp_valid_o, rsp_code_o, dirty_o);
      else pass_n++;
      total_n++; if (region_base_o !== '0 || region_len_o !== '0 || region_cnt_o !== '0)
         $display("FAIL rst_mid_tables got cnt=%h nonzero_base=%b nonzero_len=%b need all 0", region_cnt_o, |region_base_o, |region_len_o);
      else pass_n++;
      repeat (20) begin
         @(negedge clk_i);
         if (rsp_valid_o) quiet = 0;
      end
      total_n++; if (quiet !== 1'b1) $display("FAIL rst_mid_no_response got rsp seen=%b need 0", !quiet); else pass_n++;
      // a fresh commit must publish nothing if the shadow was cleared
      send_req(CMT, NONIDEM, 5'd0, '0, '0, OK, LAT_LONG, 0, obs, rdy0, stable);
      e = exp_q.pop_front();
      total_n++; if (obs !== e) $display("FAIL rst_commit code/lat got %0d/%0d need %0d/%0d", obs.code, obs.lat, e.code, e.lat); else pass_n++;
      @(negedge clk_i);
      total_n++; if (region_base_o !== pub_b || region_cnt_o !== pub_c)
         $display("FAIL rst_shadow_cleared cnt got %h need %h nonzero_base=%b", region_cnt_o, pub_c, |region_base_o);
      else pass_n++;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_exec_commit();
      test_overlap();
      test_errors();
      test_compaction();
      test_back_to_back();
      test_reset_mid_compact();
      total_n++; if (exp_q.size() != 0) $display("FAIL scoreboard_drained got %0d left need 0", exp_q.size()); else pass_n++;
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
